// File: rtl/psum_readout_quant.sv
// psum_readout_quant: triggers SFU readout, quantizes 16 psum words into a buffer, drains them over valid/ready
module psum_readout_quant #(
    parameter int psum_bw = 16,
    parameter int act_bw  = 8,
    parameter int col     = 8,
    parameter int num_o   = 16,
    parameter int rd_lat  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [3:0]              shift,
    output logic                    busy,
    output logic                    done,
    output logic                    readout_start,
    input  logic [psum_bw*col-1:0]  readout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [act_bw*col-1:0]   out_data,
    output logic [3:0]              out_addr
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] TRIG  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] CAPT  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;
    localparam logic [psum_bw-1:0] sat = psum_bw'((1 << act_bw) - 1);
    localparam logic [3:0] last = 4'(num_o - 1);
    localparam logic [3:0] wait_last = 4'(rd_lat - 2);

    logic [2:0]            state;
    logic [3:0]            sh, wait_cnt, cap_cnt, drn_cnt;
    logic [act_bw*col-1:0] mem [num_o];
    logic [act_bw*col-1:0] q;

    // ReLU, logical right shift, then clamp to the unsigned act_bw range
    function automatic logic [act_bw-1:0] quant(input logic [psum_bw-1:0] v, input logic [3:0] s);
        logic [psum_bw-1:0] t;
        t = v[psum_bw-1] ? '0 : v >> s;
        return t > sat ? {act_bw{1'b1}} : t[act_bw-1:0];
    endfunction

    assign busy      = state != IDLE;
    assign out_valid = state == DRAIN;
    assign out_addr  = out_valid ? drn_cnt : '0;
    assign out_data  = out_valid ? mem[drn_cnt] : '0;

    // quantize every lane of the incoming readout word with the latched shift
    always_comb begin
        q = '0;
        for (int i = 0; i < col; i++)
            q[act_bw*i +: act_bw] = quant(readout[psum_bw*i +: psum_bw], sh);
    end

    // capture buffer; contents are meaningless outside a pass so it carries no reset
    always_ff @(posedge clk)
        if (state == CAPT) mem[cap_cnt] <= q;

    // sequencing: trigger, wait out the readout latency, capture the burst, drain with backpressure
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            sh            <= '0;
            wait_cnt      <= '0;
            cap_cnt       <= '0;
            drn_cnt       <= '0;
            readout_start <= 1'b0;
            done          <= 1'b0;
        end else begin
            readout_start <= 1'b0;
            done          <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sh            <= shift;
                    readout_start <= 1'b1;
                    state         <= TRIG;
                end
                TRIG: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: if (wait_cnt == wait_last) state <= CAPT;
                      else wait_cnt <= wait_cnt + 4'd1;
                CAPT: begin
                    cap_cnt <= cap_cnt == last ? '0 : cap_cnt + 4'd1;
                    if (cap_cnt == last) state <= DRAIN;
                end
                DRAIN: if (out_ready) begin
                    drn_cnt <= drn_cnt == last ? '0 : drn_cnt + 4'd1;
                    if (drn_cnt == last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psum_readout_quant.sv
// tb_psum_readout_quant: randomized passes against an arithmetic reference of ReLU/shift/saturate and pass timing
module tb_psum_readout_quant;
    logic         clk = 1'b0, reset = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [3:0]   shift = '0;
    logic         busy, done, readout_start, out_valid;
    logic [127:0] readout;
    logic [63:0]  out_data;
    logic [3:0]   out_addr;
    int n_cmp = 0, n_bad = 0;
    int pix [16][8];
    int sfu_idx = 16;
    int relu_t [8] = '{-1, -32768, 0, 255, 256, 32767, 128, 1};

    psum_readout_quant dut (
        .clk(clk), .reset(reset), .start(start), .shift(shift),
        .busy(busy), .done(done), .readout_start(readout_start),
        .readout(readout), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr)
    );

    always #5 clk = ~clk;

    // SFU model: word 0 is presented two cycles after the cycle readout_start is seen
    always @(posedge clk) sfu_idx <= readout_start ? -1 : (sfu_idx < 16 ? sfu_idx + 1 : sfu_idx);

    always_comb begin
        readout = '0;
        for (int i = 0; i < 8; i++)
            readout[16*i +: 16] = (sfu_idx >= 0 && sfu_idx < 16) ? 16'(pix[sfu_idx[3:0]][i]) : 16'hBEEF;
    end

    function automatic int ref_q(int v, int s);
        int t;
        if (v < 0) return 0;
        t = v / (1 << s);
        return t > 255 ? 255 : t;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic fill(int rmode);
        for (int a = 0; a < 16; a++)
            for (int i = 0; i < 8; i++)
                pix[a][i] = rmode == 0 ? a*16 + i :
                            rmode == 1 ? relu_t[i] :
                            rmode == 2 ? (i % 2 ? 32767 : 1000) :
                            int'($urandom_range(0, 65535)) - 32768;
    endtask

    task automatic launch(int sh, int rmode);
        fill(rmode);
        @(negedge clk);
        start = 1'b1;
        shift = 4'(sh);
    endtask

    // runs one pass whose start is already asserted in the current cycle (cycle 0)
    task automatic run_pass(int sh, int rdy_mode, bit inject, bit chain, int next_sh);
        logic [63:0] exp_w [16];
        int k, last_hs, done_c;
        bit seen_v;
        for (int a = 0; a < 16; a++)
            for (int i = 0; i < 8; i++)
                exp_w[a][8*i +: 8] = 8'(ref_q(pix[a][i], sh));
        k = 0; last_hs = -1; done_c = -1; seen_v = 1'b0;
        for (int c = 1; c < 200 && done_c < 0; c++) begin
            @(negedge clk);
            start = inject && (c == 10 || c == 25);
            out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (c % 4 == 0 || c % 4 == 3) : 1'($urandom_range(0, 1));
            chk("readout_start", readout_start, c == 1);
            if (c == 1) chk("busy_running", busy, 1);
            if (out_valid) begin
                if (!seen_v) begin
                    seen_v = 1'b1;
                    chk("first_valid_cycle", c, 19);
                end
                chk("word_count_bound", k < 16, 1);
                chk("out_addr", out_addr, k & 15);
                chk("out_data", out_data, exp_w[k & 15]);
                if (out_ready) begin
                    k++;
                    last_hs = c;
                end
            end
            if (done) begin
                done_c = c;
                chk("done_cycle", c, last_hs + 1);
                chk("words_drained", k, 16);
                chk("busy_at_done", busy, 0);
                if (rdy_mode == 0) chk("done_at_35", c, 35);
            end
        end
        if (done_c < 0) chk("done_timeout", 0, 1);
        start = chain;
        if (chain) shift = 4'(next_sh);
    endtask

    initial begin
        int sh;
        bit hit;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_readout_start", readout_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", out_addr, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_trigger", readout_start, 0);

        launch(0, 0); run_pass(0, 0, 0, 0, 0);
        launch(0, 1); run_pass(0, 0, 0, 0, 0);
        launch(2, 2); run_pass(2, 0, 0, 0, 0);
        launch(3, 2); run_pass(3, 2, 0, 0, 0);
        launch(15, 2); run_pass(15, 0, 0, 0, 0);
        launch(7, 2); run_pass(7, 0, 0, 0, 0);
        launch(8, 2); run_pass(8, 2, 0, 0, 0);

        sh = $urandom_range(0, 15);
        launch(sh, 3); run_pass(sh, 1, 1, 0, 0);

        sh = $urandom_range(0, 15);
        launch(4, 3); run_pass(4, 0, 1, 1, sh);
        fill(3); run_pass(sh, 2, 0, 0, 0);

        launch(1, 3);
        hit = 1'b0;
        for (int c = 1; c < 60 && !hit; c++) begin
            @(negedge clk);
            start = 1'b0;
            out_ready = 1'b1;
            if (out_valid && out_addr == 4'd5) hit = 1'b1;
        end
        if (!hit) chk("reach_word5", 0, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_out_data", out_data, 0);
        repeat (2) @(negedge clk);
        chk("async_no_done", done, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        launch(0, 0); run_pass(0, 0, 0, 0, 0);

        for (int p = 0; p < 3; p++) begin
            sh = $urandom_range(0, 15);
            launch(sh, 3); run_pass(sh, 2, p == 1, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
